// File: rtl/apb_master_bridge.sv
// APB master bridge: turns one host request at a time into an APB SETUP/ACCESS
// sequence, decoding the target slave from the top address bits.
module apb_master_bridge #(
    parameter  int ADDR_W  = 9,
    parameter  int DATA_W  = 8,
    parameter  int NUM_SLV = 2,
    parameter  int TIMEOUT = 16,
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      transfer,
    input  logic                      READ_WRITE,
    input  logic [ADDR_W-1:0]         apb_write_paddr,
    input  logic [ADDR_W-1:0]         apb_read_paddr,
    input  logic [DATA_W-1:0]         apb_write_data,
    input  logic [STRB_W-1:0]         apb_write_strb,
    output logic [DATA_W-1:0]         apb_read_data_out,
    output logic                      PSLVERR_out,
    output logic                      done,
    output logic                      busy,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [STRB_W-1:0]         PSTRB,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);
    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic              idx_ok;
    logic [NUM_SLV-1:0] sel;
    logic              ready_sel, err_sel;
    logic [DATA_W-1:0] rdata_sel;
    logic [CNT_W-1:0]  wait_cnt;
    logic              complete, err_nxt, capture;

    generate
        if (NUM_SLV > 1) begin : g_dec
            assign idx = PADDR[ADDR_W-1 -: IDX_W];
        end else begin : g_single
            assign idx = '0;
        end
    endgenerate

    assign idx_ok = int'(idx) < NUM_SLV;

    // One-hot slave select plus the selected slave's response lines.
    always_comb begin
        sel       = '0;
        ready_sel = 1'b0;
        err_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_ok && int'(idx) == i) begin
                sel[i]    = 1'b1;
                ready_sel = PREADY[i];
                err_sel   = PSLVERR[i];
                rdata_sel = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign busy    = (state != IDLE);
    assign PENABLE = (state == ACCESS);
    assign PSEL    = busy ? sel : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        err_nxt   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    capture   = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                // Unmapped slave: no APB phases, finish with an error right away.
                if (!idx_ok) begin
                    complete = 1'b1;
                    err_nxt  = 1'b1;
                end else begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (ready_sel) begin
                    complete = 1'b1;
                    err_nxt  = err_sel;
                end else if (wait_cnt == CNT_LAST) begin
                    complete = 1'b1;
                    err_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (complete) begin
            if (transfer) begin
                capture   = 1'b1;
                state_nxt = SETUP;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE            <= 1'b0;
            PADDR             <= '0;
            PWDATA            <= '0;
            PSTRB             <= '0;
            apb_read_data_out <= '0;
            PSLVERR_out       <= 1'b0;
            done              <= 1'b0;
            wait_cnt          <= '0;
        end else begin
            done <= complete;
            if (state == ACCESS && !complete) wait_cnt <= wait_cnt + CNT_W'(1);
            else                              wait_cnt <= '0;
            if (complete) begin
                PSLVERR_out <= err_nxt;
                if (!PWRITE && !err_nxt) apb_read_data_out <= rdata_sel;
            end
            // Reads leave PWDATA alone and drive no strobes.
            if (capture) begin
                PWRITE <= !READ_WRITE;
                if (READ_WRITE) begin
                    PADDR <= apb_read_paddr;
                    PSTRB <= '0;
                end else begin
                    PADDR  <= apb_write_paddr;
                    PWDATA <= apb_write_data;
                    PSTRB  <= apb_write_strb;
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a per-cycle timeline model for a 2-slave/8-bit
// instance plus directed checks on a 3-slave/16-bit instance for decode errors.
`timescale 1ns/1ps
module tb_apb_master_bridge;
    localparam int T    = 4;
    localparam int MAXC = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // instance A: ADDR_W=9, DATA_W=8, NUM_SLV=2
    logic       transfer = 0, rw = 0;
    logic [8:0] wpaddr = 0, rpaddr = 0;
    logic [7:0] wdata = 0;
    logic [0:0] strb = 0;
    logic [7:0] a_rdata, a_pwdata;
    logic       a_err, a_done, a_busy, a_pen, a_pwrite;
    logic [1:0] a_psel, a_pready, a_pslverr;
    logic [8:0] a_paddr;
    logic [0:0] a_pstrb;
    logic [15:0] a_prdata;

    // instance B: ADDR_W=9, DATA_W=16, NUM_SLV=3
    logic        b_transfer = 0, b_rw = 0;
    logic [8:0]  b_wpaddr = 0, b_rpaddr = 0;
    logic [15:0] b_wdata = 0;
    logic [1:0]  b_strb = 0;
    logic [15:0] b_rdata, b_pwdata;
    logic        b_err, b_done, b_busy, b_pen, b_pwrite;
    logic [2:0]  b_psel, b_pready;
    logic [8:0]  b_paddr;
    logic [1:0]  b_pstrb;

    // slave behaviour for A: per-slave wait states, read data and error
    int         slv_wait [2];
    logic [7:0] slv_rd   [2];
    logic [1:0] slv_err = 2'b00;
    int         acc_cnt = 0;

    assign a_prdata   = {slv_rd[1], slv_rd[0]};
    assign a_pslverr  = slv_err;
    assign a_pready[0] = a_psel[0] & a_pen & (acc_cnt >= slv_wait[0]);
    assign a_pready[1] = a_psel[1] & a_pen & (acc_cnt >= slv_wait[1]);
    always @(posedge clk) acc_cnt <= (a_pen && a_pready == 2'b00) ? acc_cnt + 1 : 0;

    assign b_pready = b_psel & {3{b_pen}};

    wire [32:0] a_all = {a_psel, a_pen, a_pwrite, a_paddr, a_pwdata, a_pstrb,
                         a_rdata, a_err, a_done, a_busy};
    wire [50:0] b_all = {b_psel, b_pen, b_pwrite, b_paddr, b_pwdata, b_pstrb,
                         b_rdata, b_err, b_done, b_busy};

    apb_master_bridge #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(2), .TIMEOUT(T)) u_a (
        .PCLK(clk), .PRESETn(rst_n), .transfer(transfer), .READ_WRITE(rw),
        .apb_write_paddr(wpaddr), .apb_read_paddr(rpaddr),
        .apb_write_data(wdata), .apb_write_strb(strb),
        .apb_read_data_out(a_rdata), .PSLVERR_out(a_err), .done(a_done), .busy(a_busy),
        .PSEL(a_psel), .PENABLE(a_pen), .PWRITE(a_pwrite), .PADDR(a_paddr),
        .PWDATA(a_pwdata), .PSTRB(a_pstrb),
        .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr)
    );

    apb_master_bridge #(.ADDR_W(9), .DATA_W(16), .NUM_SLV(3), .TIMEOUT(T)) u_b (
        .PCLK(clk), .PRESETn(rst_n), .transfer(b_transfer), .READ_WRITE(b_rw),
        .apb_write_paddr(b_wpaddr), .apb_read_paddr(b_rpaddr),
        .apb_write_data(b_wdata), .apb_write_strb(b_strb),
        .apb_read_data_out(b_rdata), .PSLVERR_out(b_err), .done(b_done), .busy(b_busy),
        .PSEL(b_psel), .PENABLE(b_pen), .PWRITE(b_pwrite), .PADDR(b_paddr),
        .PWDATA(b_pwdata), .PSTRB(b_pstrb),
        .PRDATA({16'hBEEF, 16'h1234, 16'h5678}), .PREADY(b_pready), .PSLVERR(3'b000)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs of A per cycle number (cycle n = after the n-th rising edge).
    bit [1:0] exp_psel  [MAXC];
    bit       exp_pen   [MAXC];
    bit       exp_busy  [MAXC];
    bit       exp_done  [MAXC];
    bit       exp_pwrite[MAXC];
    bit       exp_err   [MAXC];
    bit [8:0] exp_paddr [MAXC];
    bit [7:0] exp_pwdata[MAXC];
    bit [7:0] exp_rdata [MAXC];
    bit       exp_pstrb [MAXC];
    int       free_at = 0;

    task automatic model_cap(input int p);
        bit       rd  = rw;
        bit [8:0] a   = rd ? rpaddr : wpaddr;
        int       idx = int'(a[8]);
        int       w   = slv_wait[idx];
        int       n   = (w < T) ? w + 1 : T;
        int       d   = p + n + 1;
        bit       e   = (w < T) ? slv_err[idx] : 1'b1;
        for (int c = p; c < MAXC; c++) begin
            exp_paddr[c]  = a;
            exp_pwrite[c] = !rd;
            exp_pstrb[c]  = rd ? 1'b0 : strb[0];
            if (!rd) exp_pwdata[c] = wdata;
        end
        for (int c = p; c < d; c++) begin
            exp_busy[c] = 1'b1;
            exp_psel[c] = 2'(1 << idx);
            exp_pen[c]  = (c > p);
        end
        exp_done[d] = 1'b1;
        for (int c = d; c < MAXC; c++) begin
            exp_err[c] = e;
            if (rd && !e) exp_rdata[c] = slv_rd[idx];
        end
        free_at = d;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                free_at = 0;
                for (int c = cyc; c < MAXC; c++) begin
                    exp_psel[c] = 0; exp_pen[c] = 0; exp_busy[c] = 0; exp_done[c] = 0;
                    exp_pwrite[c] = 0; exp_err[c] = 0; exp_paddr[c] = 0;
                    exp_pwdata[c] = 0; exp_rdata[c] = 0; exp_pstrb[c] = 0;
                end
            end else if (transfer && cyc >= free_at && cyc < MAXC - 40) begin
                model_cap(cyc);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && cyc < MAXC) begin
                chk("m_psel",   64'(a_psel),   64'(exp_psel[cyc]));
                chk("m_penable",64'(a_pen),    64'(exp_pen[cyc]));
                chk("m_busy",   64'(a_busy),   64'(exp_busy[cyc]));
                chk("m_done",   64'(a_done),   64'(exp_done[cyc]));
                chk("m_pwrite", 64'(a_pwrite), 64'(exp_pwrite[cyc]));
                chk("m_paddr",  64'(a_paddr),  64'(exp_paddr[cyc]));
                chk("m_pwdata", 64'(a_pwdata), 64'(exp_pwdata[cyc]));
                chk("m_pstrb",  64'(a_pstrb),  64'(exp_pstrb[cyc]));
                chk("m_rdata",  64'(a_rdata),  64'(exp_rdata[cyc]));
                chk("m_pslverr",64'(a_err),    64'(exp_err[cyc]));
            end
        end
    end

    initial begin
        slv_wait[0] = 0; slv_wait[1] = 0;
        slv_rd[0] = 8'h00; slv_rd[1] = 8'h00;
        repeat (2) tick();
        chk("reset_a", 64'(a_all), 64'(0));
        chk("reset_b", 64'(b_all), 64'(0));
        rst_n = 1'b1;
        tick();

        // zero-wait write to slave 0
        wpaddr = 9'h005; wdata = 8'hA5; strb = 1'b1; rw = 1'b0; transfer = 1'b1;
        tick(); transfer = 1'b0;
        chk("wr_setup", 64'({a_psel, a_pen}), 64'(3'b010));
        tick();
        chk("wr_access", 64'({a_psel, a_pen, a_pwdata, a_done}), 64'({2'b01, 1'b1, 8'hA5, 1'b0}));
        tick();
        chk("wr_done", 64'({a_done, a_err, a_busy}), 64'(3'b100));

        // read slave 1 with 3 wait states; host inputs wiggle mid-transfer
        slv_wait[1] = 3; slv_rd[1] = 8'h3C; rpaddr = 9'h10A; rw = 1'b1; transfer = 1'b1;
        tick(); transfer = 1'b0; rw = 1'b0; wpaddr = 9'h1FF; rpaddr = 9'h000;
        for (int k = 0; k < 5; k++) begin
            chk("rd1_wait", 64'({a_psel, a_done}), 64'(3'b100));
            tick();
        end
        chk("rd1_done", 64'({a_done, a_err, a_rdata}), 64'({1'b1, 1'b0, 8'h3C}));

        // timeout on slave 0
        tick();
        slv_wait[0] = 100; slv_rd[0] = 8'h77; rpaddr = 9'h020; rw = 1'b1; transfer = 1'b1;
        tick(); transfer = 1'b0;
        repeat (4) tick();
        chk("to_pending", 64'({a_pen, a_done}), 64'(2'b10));
        tick();
        chk("to_done", 64'({a_done, a_err, a_rdata}), 64'({1'b1, 1'b1, 8'h3C}));

        // write with slave error, one wait state
        slv_wait[1] = 1; slv_err[1] = 1'b1;
        wpaddr = 9'h1F0; wdata = 8'h5A; strb = 1'b1; rw = 1'b0; transfer = 1'b1;
        tick(); transfer = 1'b0;
        repeat (2) tick();
        chk("wrerr_pend", 64'(a_done), 64'(0));
        tick();
        chk("wrerr_done", 64'({a_done, a_err}), 64'(2'b11));
        slv_err[1] = 1'b0;

        // back-to-back: write then read with transfer held high
        slv_wait[0] = 0; slv_wait[1] = 0; slv_rd[1] = 8'hE1;
        wpaddr = 9'h0AA; wdata = 8'hC3; strb = 1'b1; rw = 1'b0; transfer = 1'b1;
        tick();
        rw = 1'b1; rpaddr = 9'h1B0;
        tick();
        chk("b2b_acc1", 64'({a_psel, a_pen, a_pwrite}), 64'(4'b0111));
        tick();
        chk("b2b_setup2", 64'({a_done, a_busy, a_psel, a_pen, a_pwrite}),
            64'({1'b1, 1'b1, 2'b10, 1'b0, 1'b0}));
        transfer = 1'b0;
        repeat (2) tick();
        chk("b2b_done2", 64'({a_done, a_err, a_rdata}), 64'({1'b1, 1'b0, 8'hE1}));

        // read with slave error keeps read data
        tick();
        slv_err[0] = 1'b1; slv_rd[0] = 8'h99; rpaddr = 9'h040; rw = 1'b1; transfer = 1'b1;
        tick(); transfer = 1'b0;
        repeat (2) tick();
        chk("rderr_done", 64'({a_done, a_err, a_rdata}), 64'({1'b1, 1'b1, 8'hE1}));
        slv_err[0] = 1'b0;

        // asynchronous reset in the middle of ACCESS
        slv_wait[1] = 100; wpaddr = 9'h123; wdata = 8'h3E; rw = 1'b0; transfer = 1'b1;
        tick(); transfer = 1'b0;
        tick();
        chk("mid_penable", 64'(a_pen), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_a", 64'(a_all), 64'(0));
        chk("rst_async_b", 64'(b_all), 64'(0));
        wpaddr = 9'h003; wdata = 8'h81; strb = 1'b1; transfer = 1'b1;
        repeat (2) tick();
        chk("rst_hold", 64'(a_busy), 64'(0));
        rst_n = 1'b1;
        tick(); transfer = 1'b0;
        chk("post_rst_cap", 64'({a_busy, a_psel, a_pen, a_paddr}),
            64'({1'b1, 2'b01, 1'b0, 9'h003}));
        repeat (2) tick();
        chk("post_rst_done", 64'({a_done, a_err, a_rdata}), 64'({1'b1, 1'b0, 8'h00}));

        // instance B: decode error, valid read, strobed write, decode error on read
        tick();
        b_rpaddr = 9'h180; b_rw = 1'b1; b_transfer = 1'b1;
        tick(); b_transfer = 1'b0;
        chk("dec_setup", 64'({b_busy, b_psel, b_pen, b_done}), 64'({1'b1, 3'b000, 1'b0, 1'b0}));
        tick();
        chk("dec_done", 64'({b_done, b_err, b_busy, b_psel, b_rdata}),
            64'({1'b1, 1'b1, 1'b0, 3'b000, 16'h0000}));
        b_rpaddr = 9'h100; b_transfer = 1'b1;
        tick(); b_transfer = 1'b0;
        chk("b_rd_setup", 64'(b_psel), 64'(3'b100));
        repeat (2) tick();
        chk("b_rd_done", 64'({b_done, b_err, b_rdata}), 64'({1'b1, 1'b0, 16'hBEEF}));
        b_wpaddr = 9'h080; b_wdata = 16'h1357; b_strb = 2'b10; b_rw = 1'b0; b_transfer = 1'b1;
        tick(); b_transfer = 1'b0;
        chk("b_wr_setup", 64'({b_psel, b_pwrite, b_pstrb, b_pwdata}),
            64'({3'b010, 1'b1, 2'b10, 16'h1357}));
        repeat (2) tick();
        chk("b_wr_done", 64'({b_done, b_err, b_rdata}), 64'({1'b1, 1'b0, 16'hBEEF}));
        b_rpaddr = 9'h1FF; b_rw = 1'b1; b_transfer = 1'b1;
        tick(); b_transfer = 1'b0;
        tick();
        chk("dec_rd_keep", 64'({b_done, b_err, b_rdata, b_pstrb}),
            64'({1'b1, 1'b1, 16'hBEEF, 2'b00}));

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
